// File: rtl/dds_pkg.sv
// Shared DDS definitions used by the address generator and the
// frequency meter: common clock rate, frequency word width, meter states.
package dds_pkg;

   localparam int CLK_FREQ = 50_000_000;
   localparam int FREQ_W   = 20;

   typedef enum logic [1:0] {
      IDLE,
      GATE,
      DONE
   } meter_state_t;

endpackage

// File: rtl/sig_sync_edge.sv
// Brings an asynchronous waveform into the clk domain and flags its
// rising edges as a one-cycle pulse.
module sig_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic o_edge
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("sig_sync_edge: SYNC_STAGES must be >= 2");
   end

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;
   logic                   w_sync_last;

   assign w_sync_last = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
         r_hist <= w_sync_last;
      end
   end

   // Both terms come from flops, so the pulse is glitch-free.
   assign o_edge = w_sync_last & ~r_hist;

endmodule

// File: rtl/freq_meter.sv
// Gate-window frequency meter: counts synchronized rising edges of sig_in
// over GATE_CYCLES clocks and reports the result as edges per gate.
module freq_meter
   import dds_pkg::*;
#(
   parameter int GATE_CYCLES = CLK_FREQ,
   parameter int FREQ_W      = dds_pkg::FREQ_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sig_in,
   input  logic              enable,
   output logic [FREQ_W-1:0] freq_out,
   output logic              freq_valid,
   output logic              overflow,
   output logic              busy
);

   if (GATE_CYCLES < 2) begin : g_bad_gate
      $error("freq_meter: GATE_CYCLES must be >= 2");
   end

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("freq_meter: SYNC_STAGES must be >= 2");
   end

   localparam int GW = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

   meter_state_t      r_state;
   logic [GW-1:0]     r_gate_cnt;
   logic [FREQ_W-1:0] r_edge_cnt;
   logic              r_sat;
   logic [FREQ_W-1:0] r_freq;
   logic              r_ovf;
   logic              r_valid;
   logic              r_busy;

   logic              w_edge;
   logic              w_at_max;
   logic [FREQ_W-1:0] w_cnt_next;
   logic              w_sat_next;

   sig_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst   (rst),
      .sig_in(sig_in),
      .o_edge(w_edge)
   );

   // Saturating edge count; the sticky flag records any lost increment.
   always_comb begin
      w_at_max   = &r_edge_cnt;
      w_cnt_next = r_edge_cnt;
      if (w_edge && !w_at_max) begin
         w_cnt_next = r_edge_cnt + FREQ_W'(1);
      end
      w_sat_next = r_sat | (w_edge & w_at_max);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_gate_cnt <= '0;
         r_edge_cnt <= '0;
         r_sat      <= 1'b0;
         r_freq     <= '0;
         r_ovf      <= 1'b0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (enable) begin
                  r_state    <= GATE;
                  r_busy     <= 1'b1;
                  r_gate_cnt <= '0;
                  r_edge_cnt <= '0;
                  r_sat      <= 1'b0;
               end
            end
            GATE: begin
               if (!enable) begin
                  r_state    <= IDLE;
                  r_busy     <= 1'b0;
                  r_gate_cnt <= '0;
                  r_edge_cnt <= '0;
                  r_sat      <= 1'b0;
               end else if (r_gate_cnt == GATE_LAST) begin
                  r_freq  <= w_cnt_next;
                  r_ovf   <= w_sat_next;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= DONE;
               end else begin
                  r_gate_cnt <= r_gate_cnt + GW'(1);
                  r_edge_cnt <= w_cnt_next;
                  r_sat      <= w_sat_next;
               end
            end
            DONE: begin
               r_gate_cnt <= '0;
               r_sat      <= 1'b0;
               // An edge here opens the next window so none are lost.
               if (enable) begin
                  r_state    <= GATE;
                  r_busy     <= 1'b1;
                  r_edge_cnt <= FREQ_W'(w_edge);
               end else begin
                  r_state    <= IDLE;
                  r_edge_cnt <= '0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign freq_out   = r_freq;
   assign freq_valid = r_valid;
   assign overflow   = r_ovf;
   assign busy       = r_busy;

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: a 20-bit and an 8-bit meter share one
// stimulus; expected window counts come from a log of driven rises.
module tb_freq_meter;

   localparam int     G     = 1000;
   localparam int     NMAX  = 32768;
   localparam longint MAX20 = (64'd1 << 20) - 1;
   localparam longint MAX8  = 255;

   logic        clk;
   logic        rst;
   logic        sig_in;
   logic        enable;
   logic [19:0] f20;
   logic        v20, o20, b20;
   logic [7:0]  f8;
   logic        v8, o8, b8;

   int n_run  = 0;
   int n_fail = 0;
   int cyc    = 0;

   int gen_period = 0;
   int gen_phase  = 0;
   bit rose [0:NMAX-1];

   int qr20[$];
   int qr8[$];
   longint last_exp20 = 0;

   freq_meter #(
      .GATE_CYCLES(G),
      .FREQ_W     (20),
      .SYNC_STAGES(2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sig_in    (sig_in),
      .enable    (enable),
      .freq_out  (f20),
      .freq_valid(v20),
      .overflow  (o20),
      .busy      (b20)
   );

   freq_meter #(
      .GATE_CYCLES(G),
      .FREQ_W     (8),
      .SYNC_STAGES(2)
   ) dut8 (
      .clk       (clk),
      .rst       (rst),
      .sig_in    (sig_in),
      .enable    (enable),
      .freq_out  (f8),
      .freq_valid(v8),
      .overflow  (o8),
      .busy      (b8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Square-wave source, changed on negedge; every 0->1 is logged.
   initial begin
      logic nv;
      sig_in = 1'b0;
      forever begin
         @(negedge clk);
         nv = 1'b0;
         if (gen_period > 0 && cyc >= gen_phase)
            nv = ((cyc - gen_phase) % gen_period) < (gen_period / 2);
         if (nv && !sig_in && cyc < NMAX) rose[cyc] = 1'b1;
         sig_in = nv;
      end
   end

   // Window model: a rise driven after posedge r is counted at posedge r+3.
   initial begin
      int st, cnt, gc, e;
      st = 0; cnt = 0; gc = 0;
      forever begin
         @(posedge clk);
         cyc++;
         e = (cyc >= 3 && cyc - 3 < NMAX && rose[cyc-3]) ? 1 : 0;
         if (rst) begin
            st = 0; cnt = 0; gc = 0;
         end else begin
            case (st)
               0: if (enable) begin
                  st = 1; gc = 0; cnt = 0;
               end
               1: if (!enable) begin
                  st = 0; gc = 0; cnt = 0;
               end else begin
                  cnt += e;
                  if (gc == G - 1) begin
                     qr20.push_back(cnt);
                     qr8.push_back(cnt);
                     st = 2;
                  end
                  gc++;
               end
               default: begin
                  gc = 0;
                  if (enable) begin
                     st = 1; cnt = e;
                  end else begin
                     st = 0; cnt = 0;
                  end
               end
            endcase
         end
      end
   end

   // Result monitors pop the scoreboard on each freq_valid pulse.
   initial forever begin
      int raw;
      longint ex;
      @(negedge clk);
      if (v20) begin
         if (qr20.size() == 0) chk("sb20_unexpected", 1, 0);
         else begin
            raw = qr20.pop_front();
            ex  = (raw > MAX20) ? MAX20 : raw;
            last_exp20 = ex;
            chk("sb20_freq", f20, ex);
            chk("sb20_ovf", o20, (raw > MAX20) ? 1 : 0);
         end
      end
      if (v8) begin
         if (qr8.size() == 0) chk("sb8_unexpected", 1, 0);
         else begin
            raw = qr8.pop_front();
            ex  = (raw > MAX8) ? MAX8 : raw;
            chk("sb8_freq", f8, ex);
            chk("sb8_ovf", o8, (raw > MAX8) ? 1 : 0);
         end
      end
   end

   task automatic wait_valid(input string tag, input int budget,
                             output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (v20) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk({"timeout_", tag}, 0, 1);
   endtask

   initial begin
      bit ok;
      int t_en, t_last, nv, c;
      rst = 1'b1;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_freq", f20, 0);
      chk("rst_valid", v20, 0);
      chk("rst_ovf", o20, 0);
      chk("rst_busy", b20, 0);
      chk("rst_freq8", f8, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Period 10, then 20 in continuous mode.
      gen_phase = cyc; gen_period = 10;
      enable = 1'b1;
      t_en = cyc + 1;
      repeat (10) @(negedge clk);
      chk("win_busy", b20, 1);
      wait_valid("first", G + 100, ok);
      chk("first_latency", cyc + 1 - t_en, G + 1);
      chk("first_freq", f20, 100);
      chk("first_ovf", o20, 0);
      chk("done_busy", b20, 0);
      t_last = cyc;
      gen_phase = cyc; gen_period = 20;
      wait_valid("second", G + 100, ok);
      chk("gap2", cyc - t_last, G + 1);
      t_last = cyc;
      wait_valid("third", G + 100, ok);
      chk("gap3", cyc - t_last, G + 1);

      // Saturation on the 8-bit meter, then recovery.
      gen_phase = cyc; gen_period = 2;
      wait_valid("p2", G + 100, ok);
      chk("p2_freq8", f8, 255);
      chk("p2_ovf8", o8, 1);
      gen_phase = cyc; gen_period = 8;
      wait_valid("p8", G + 100, ok);
      chk("p8_ovf8", o8, 0);

      // Abort mid-window, then a fresh window.
      repeat (500) @(negedge clk);
      chk("pre_abort_busy", b20, 1);
      enable = 1'b0;
      @(negedge clk);
      chk("abort_busy", b20, 0);
      nv = 0;
      repeat (G + 100) begin
         @(negedge clk);
         if (v20) nv++;
      end
      chk("abort_no_valid", nv, 0);
      chk("abort_hold", f20, last_exp20);
      enable = 1'b1;
      wait_valid("reenable", G + 100, ok);
      chk("reenable_freq", f20, 125);
      chk("reenable_freq8", f8, 125);
      chk("reenable_ovf8", o8, 0);
      enable = 1'b0;
      @(negedge clk);
      chk("idle_busy", b20, 0);

      // Synchronous reset mid-window.
      gen_period = 0;
      repeat (10) @(negedge clk);
      enable = 1'b1;
      repeat (300) @(negedge clk);
      chk("rst_win_busy", b20, 1);
      rst = 1'b1;
      enable = 1'b0;
      #2;
      chk("rst_sync_hold", f20, last_exp20);
      @(negedge clk);
      chk("midrst_freq", f20, 0);
      chk("midrst_ovf", o20, 0);
      chk("midrst_valid", v20, 0);
      chk("midrst_busy", b20, 0);
      chk("midrst_freq8", f8, 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Period G+1 with every edge landing in the DONE cycle.
      c = cyc;
      gen_phase = c + 1 - 3 + (G + 1);
      gen_period = G + 1;
      enable = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         wait_valid("aligned", G + 100, ok);
         if (n >= 2) chk("aligned_one", f20, 1);
         if (n == 4) enable = 1'b0;
      end
      repeat (20) @(negedge clk);
      chk("final_idle_busy", b20, 0);
      chk("sb20_drained", qr20.size(), 0);
      chk("sb8_drained", qr8.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
